// File: rtl/alu_op_sequencer.sv
// Command front end for the 16-bit ALU: buffers {opcode,a,b} commands in a small FIFO,
// issues them one at a time with stable operands, and returns each y tagged with its opcode.
module alu_op_sequencer #(
  parameter int DATA_W  = 16,
  parameter int OP_W    = 2,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OP_W-1:0]            cmd_opcode,
  input  logic [DATA_W-1:0]          cmd_a,
  input  logic [DATA_W-1:0]          cmd_b,
  output logic [OP_W-1:0]            alu_opcode,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  input  logic [DATA_W-1:0]          alu_y,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_W-1:0]          res_data,
  output logic [OP_W-1:0]            res_opcode,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [OP_W-1:0]   fifo_op [DEPTH];
  logic [DATA_W-1:0] fifo_a  [DEPTH];
  logic [DATA_W-1:0] fifo_b  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [1:0]        state;
  logic [WCNT_W-1:0] wcnt;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && cmd_ready;
  // The FSM takes the head either from IDLE or straight out of HOLD on the result handshake.
  assign pop        = !empty && ((state == IDLE) || ((state == HOLD) && res_ready));
  assign fifo_count = count;
  assign busy       = (state != IDLE) || !empty;

  // Command storage: payload only, pointers and count carry the state.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr] <= cmd_opcode;
      fifo_a[wr_ptr]  <= cmd_a;
      fifo_b[wr_ptr]  <= cmd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Issue / wait / hold sequencer; alu_* only change when a new command is popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wcnt       <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_opcode <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_opcode <= fifo_op[rd_ptr];
            alu_a      <= fifo_a[rd_ptr];
            alu_b      <= fifo_b[rd_ptr];
            wcnt       <= WCNT_W'(ALU_LAT);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt == '0) begin
            res_data   <= alu_y;
            res_opcode <= alu_opcode;
            res_valid  <= 1'b1;
            state      <= HOLD;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              alu_opcode <= fifo_op[rd_ptr];
              alu_a      <= fifo_a[rd_ptr];
              alu_b      <= fifo_b[rd_ptr];
              wcnt       <= WCNT_W'(ALU_LAT);
              state      <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
